frame_mem_arbiter: RTL

- Shares the single-port frame SRAM (20-bit address, 16-bit data) between two requesters: the frame-capture writer and a frame reader (processing/readout path).
- The capture writer streams at pixel rate and cannot be stalled, so its writes enter a small write FIFO with priority drain.
- The reader uses a request/acknowledge handshake, with data returned after a fixed latency.
- A starvation guard caps reader wait time.
- Sits between the capture block and the SRAM pad controller, in the VGA pixel-clock domain.

---
 rtl/frame_mem_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/frame_mem_arbiter.sv
`default_nettype none
// ============================================================================
// frame_mem_arbiter: shares one frame SRAM between a capture write FIFO and a reader.
// Revision: 1.0
// ============================================================================
module frame_mem_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WFIFO_DEPTH = 4,
  parameter int READ_LAT    = 2,
  parameter int MAX_RD_WAIT = 8
) (
  input  logic                           iCLK,
  input  logic                           iRST,
  input  logic                           iWrWE,
  input  logic [ADDR_W-1:0]              iWrAddr,
  input  logic [DATA_W-1:0]              iWrData,
  input  logic                           iRdReq,
  input  logic [ADDR_W-1:0]              iRdAddr,
  output logic                           oRdAck,
  output logic                           oRdValid,
  output logic [DATA_W-1:0]              oRdData,
  output logic [ADDR_W-1:0]              oSramAddr,
  output logic [DATA_W-1:0]              oSramData,
  output logic                           oSramWE,
  output logic                           oSramOE,
  input  logic [DATA_W-1:0]              iSramData,
  output logic                           oWrOverflow,
  output logic                           oBusy,
  output logic [$clog2(WFIFO_DEPTH):0]   oFifoCount
);

  localparam int PTR_W  = $clog2(WFIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_RD_WAIT + 1);
  localparam int ENT_W  = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(WFIFO_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_RD_WAIT);

  // Encoding chosen so bit 0 drives WE and bit 1 drives OE straight from the flop.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_READ  = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic [ENT_W-1:0]      fifo_q [WFIFO_DEPTH];
  logic [ENT_W-1:0]      fifo_d [WFIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [READ_LAT-1:0]   rd_pipe_q, rd_pipe_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]     rd_data_q, rd_data_d;
  logic [ADDR_W-1:0]     sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0]     sram_data_q, sram_data_d;
  logic                  overflow_q, overflow_d;

  logic                  forced_rd;
  logic                  rd_issue;
  logic                  pop;
  logic                  push;
  logic [ENT_W-1:0]      head;

  always_comb begin
    head      = fifo_q[rd_ptr_q];
    forced_rd = iRdReq && (wait_q >= WAIT_MAX);

    if (forced_rd)                 state_d = ST_READ;
    else if (count_q != '0)        state_d = ST_WRITE;
    else if (iRdReq)               state_d = ST_READ;
    else                           state_d = ST_IDLE;

    rd_issue = (state_d == ST_READ) && !iRST;
    pop      = (state_d == ST_WRITE);
    // A full FIFO still accepts when the head leaves in the same cycle.
    push     = iWrWE && ((count_q != FULL_CNT) || pop);

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {iWrAddr, iWrData};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    overflow_d = overflow_q || (iWrWE && !push);

    if (!iRdReq || rd_issue)       wait_d = '0;
    else if (wait_q != WAIT_MAX)   wait_d = wait_q + WAIT_W'(1);
    else                           wait_d = wait_q;

    sram_addr_d = sram_addr_q;
    sram_data_d = sram_data_q;
    if (state_d == ST_WRITE) begin
      sram_addr_d = head[ENT_W-1:DATA_W];
      sram_data_d = head[DATA_W-1:0];
    end else if (state_d == ST_READ) begin
      sram_addr_d = iRdAddr;
    end

    rd_pipe_d    = rd_pipe_q << 1;
    rd_pipe_d[0] = rd_issue;
    rd_valid_d   = rd_pipe_q[READ_LAT-1];
    rd_data_d    = rd_pipe_q[READ_LAT-1] ? iSramData : rd_data_q;
  end

  always_ff @(posedge iCLK) begin
    fifo_q <= fifo_d;
    if (iRST) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wait_q      <= '0;
      rd_pipe_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      sram_addr_q <= '0;
      sram_data_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
      rd_pipe_q   <= rd_pipe_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      sram_addr_q <= sram_addr_d;
      sram_data_q <= sram_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign oRdAck      = rd_issue;
  assign oRdValid    = rd_valid_q;
  assign oRdData     = rd_data_q;
  assign oSramAddr   = sram_addr_q;
  assign oSramData   = sram_data_q;
  assign oSramWE     = state_q[0];
  assign oSramOE     = state_q[1];
  assign oWrOverflow = overflow_q;
  assign oFifoCount  = count_q;
  assign oBusy       = (count_q != '0) || (|rd_pipe_q) || rd_valid_q;

endmodule
`default_nettype wire
